// File: rtl/adder6bit_check_seq.sv
// Sequencing/checking stage around a 6-bit ripple adder: drives operands, waits SETTLE_CYC, captures and checks the sum.
// Optional build macro ADDER_CHK_LFSR_STIM_EN replaces the input stream with an internal 12-bit LFSR.
module adder6bit_check_seq #(
  parameter int SETTLE_CYC = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [5:0]           in_a,
  input  logic [5:0]           in_b,
  output logic [5:0]           add_a,
  output logic [5:0]           add_b,
  input  logic [6:0]           add_sum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [6:0]           out_sum,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 clr_err
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

  generate
    if (SETTLE_CYC < 1) begin : g_bad_settle
      $error("SETTLE_CYC must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] settle_cnt;
  logic             start, capture, done_hold;
  logic [5:0]       start_a, start_b;
  logic [6:0]       golden_sum;
  logic             mismatch;

`ifdef ADDER_CHK_LFSR_STIM_EN
  logic [11:0] lfsr;
  logic        lfsr_fb;
  logic        unused_in;

  assign unused_in = ^{in_valid, in_a, in_b};
  assign in_ready  = 1'b0;
  assign start     = (state == IDLE);
  assign start_a   = lfsr[11:6];
  assign start_b   = lfsr[5:0];
  assign lfsr_fb   = lfsr[11] ^ lfsr[10] ^ lfsr[9] ^ lfsr[3];

  // Stimulus generator steps once per started transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 12'hACE;
    end else if (start) begin
      lfsr <= {lfsr[10:0], lfsr_fb};
    end
  end
`else
  assign in_ready = (state == IDLE);
  assign start    = (state == IDLE) && in_valid;
  assign start_a  = in_a;
  assign start_b  = in_b;
`endif

  // Golden sum kept at 7 bits so the carry-out is checked too
  assign golden_sum = {1'b0, add_a} + {1'b0, add_b};
  assign mismatch   = (add_sum != golden_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    done_hold  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == '0) begin
          capture    = 1'b1;
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          done_hold  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a      <= '0;
      add_b      <= '0;
      settle_cnt <= '0;
      out_sum    <= '0;
      out_err    <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (start) begin
        add_a      <= start_a;
        add_b      <= start_b;
        settle_cnt <= CNT_LOAD;
      end else if (state == SETTLE && settle_cnt != '0) begin
        settle_cnt <= settle_cnt - 1'b1;
      end
      if (capture) begin
        out_sum   <= add_sum;
        out_err   <= mismatch;
        out_valid <= 1'b1;
      end else if (done_hold) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Clear has priority over a same-edge increment; counter sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr_err) begin
      err_cnt <= '0;
    end else if (capture && mismatch && !(&err_cnt)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_adder6bit_check_seq.sv
// Self-checking bench for adder6bit_check_seq: emulates the adder (with optional faults) and scores results against a model.
module tb_adder6bit_check_seq;

  localparam int SETTLE  = 2;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = 255;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [5:0]       in_a, in_b, add_a, add_b;
  logic [6:0]       add_sum, out_sum;
  logic             out_valid, out_ready, out_err, clr_err;
  logic [CNT_W-1:0] err_cnt;
  logic [1:0]       fault_mode;
  logic [6:0]       fault_mask;

  int checks = 0;
  int fails  = 0;
  int model_cnt = 0;

  always #5 clk = ~clk;

  adder6bit_check_seq #(.SETTLE_CYC(SETTLE), .ERR_CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_err(out_err), .err_cnt(err_cnt), .clr_err(clr_err)
  );

  // Adder emulation: 0 = correct, 1 = sum[6] stuck at 0, 2 = XOR fault mask
  function automatic logic [6:0] adder_out(input logic [5:0] a, input logic [5:0] b,
                                           input logic [1:0] mode, input logic [6:0] mask);
    int s;
    s = int'(a) + int'(b);
    case (mode)
      2'd1:    s = s % 64;
      2'd2:    s = s ^ int'(mask);
      default: s = s;
    endcase
    return 7'(s);
  endfunction

  assign add_sum = adder_out(add_a, add_b, fault_mode, fault_mask);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] a, input logic [5:0] b, input int hold_cycles, input bit clr);
    int         lat;
    logic [6:0] exp_sum;
    bit         exp_err;
    exp_sum = adder_out(a, b, fault_mode, fault_mask);
    exp_err = (int'(exp_sum) != int'(a) + int'(b));
    if (clr) model_cnt = 0;
    else if (exp_err && model_cnt < CNT_MAX) model_cnt++;

    checkOutput("idle_ready", in_ready, 1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(posedge clk);
    @(negedge clk);
    in_a = ~a;
    in_b = ~b;
    checkOutput("drive_a", add_a, a);
    checkOutput("drive_b", add_b, b);
    checkOutput("settle_ready", in_ready, 0);
    lat = 0;
    clr_err = clr && (SETTLE == 1);
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
      clr_err = clr && (lat + 1 == SETTLE);
    end
    clr_err = 1'b0;
    checkOutput("latency", lat, SETTLE);
    for (int i = 0; i <= hold_cycles; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_ready", in_ready, 0);
      checkOutput("out_sum", out_sum, exp_sum);
      checkOutput("out_err", out_err, exp_err);
      checkOutput("err_cnt", err_cnt, model_cnt);
      checkOutput("hold_a", add_a, a);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("drain_valid", out_valid, 0);
    checkOutput("drain_ready", in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    clr_err = 1'b0;
    fault_mode = 2'd0;
    fault_mask = '0;
    #2;
    checkOutput("rst_ready", in_ready, 1);
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_sum", out_sum, 0);
    checkOutput("rst_err", out_err, 0);
    checkOutput("rst_cnt", err_cnt, 0);
    checkOutput("rst_a", add_a, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Correct adder: corner operands and back-to-back pairs with a stalled consumer
    applyStimulus(6'd63, 6'd63, 0, 1'b0);
    applyStimulus(6'd0, 6'd0, 5, 1'b0);
    applyStimulus(6'd1, 6'd62, 5, 1'b0);
    applyStimulus(6'd32, 6'd32, 5, 1'b0);

    // Carry-out stuck at zero
    fault_mode = 2'd1;
    applyStimulus(6'd63, 6'd1, 1, 1'b0);
    applyStimulus(6'd5, 6'd5, 1, 1'b0);

    // Clear while idle
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    model_cnt = 0;
    checkOutput("idle_clr", err_cnt, 0);

    // Randomised mix of fault modes, stall lengths and clears
    for (int n = 0; n < 60; n++) begin
      fault_mode = 2'($urandom_range(0, 2));
      fault_mask = 7'($urandom_range(0, 127));
      applyStimulus(6'($urandom), 6'($urandom), $urandom_range(0, 3), $urandom_range(0, 7) == 0);
    end

    // Saturation: every pair overflows into sum[6], which is stuck low
    fault_mode = 2'd1;
    applyStimulus(6'd40, 6'd40, 0, 1'b1);
    for (int n = 0; n < 260; n++) begin
      applyStimulus(6'(32 + $urandom_range(0, 31)), 6'(32 + $urandom_range(0, 31)), 0, 1'b0);
    end
    checkOutput("sat_cnt", err_cnt, CNT_MAX);
    applyStimulus(6'd50, 6'd20, 0, 1'b1);
    checkOutput("clr_wins", err_cnt, 0);
    applyStimulus(6'd63, 6'd1, 0, 1'b0);

    // Reset one cycle into SETTLE discards the transaction
    in_valid = 1'b1;
    in_a = 6'd40;
    in_b = 6'd40;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ready", in_ready, 1);
    checkOutput("mid_rst_valid", out_valid, 0);
    checkOutput("mid_rst_a", add_a, 0);
    checkOutput("mid_rst_b", add_b, 0);
    checkOutput("mid_rst_sum", out_sum, 0);
    checkOutput("mid_rst_err", out_err, 0);
    checkOutput("mid_rst_cnt", err_cnt, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("post_rst_valid", out_valid, 0);
      checkOutput("post_rst_ready", in_ready, 1);
    end
    fault_mode = 2'd0;
    applyStimulus(6'd2, 6'd3, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
